system_bus_router: RTL and testbench

- Parametrised successor to the fixed system bus: one master port fans out to NUM_SLAVES slave ports.
- Slaves are decoded by addr[31:28] region IDs held in a parameter table.
- Up to MAX_OUTSTANDING reads may be in flight; responses are returned to the master strictly in request order, using a tag FIFO.
- Sits between the CPU bus master and the peripheral/memory interfaces. Unmapped accesses get a default response and set an error flag.

---
 rtl/system_bus_pkg.sv | 16 +
 rtl/bus_tag_fifo.sv | 64 ++++++
 rtl/system_bus_router.sv | 129 ++++++++++++
 tb/tb_system_bus_router.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_bus_pkg.sv
// rtl/system_bus_pkg.sv - shared types, region field bounds and tag sizing for the system bus router
package system_bus_pkg;

    typedef logic [31:2] bus_addr_t;
    typedef logic [31:0] bus_data_t;
    typedef logic [3:0]  bus_be_t;

    localparam int REGION_MSB = 31;
    localparam int REGION_LSB = 28;

    // One code per slave plus one extra code reserved for "unmapped"
    function automatic int tag_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bus_tag_fifo.sv
// rtl/bus_tag_fifo.sv - tag FIFO with a registered head output, used to order read responses
module bus_tag_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = head_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is precomputed so the consumer sees a flop, not a memory read
    always_comb begin
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push && ((count_q - (AW+1)'(do_pop)) == '0)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/system_bus_router.sv
// rtl/system_bus_router.sv - one master to NUM_SLAVES slaves with region decode and in-order read return
module system_bus_router
    import system_bus_pkg::*;
#(
    parameter int                      NUM_SLAVES        = 4,
    parameter logic [NUM_SLAVES*4-1:0] REGION_IDS        = {4'h4, 4'h3, 4'h2, 4'h1},
    parameter int                      MAX_OUTSTANDING   = 4,
    parameter logic [31:0]             DEFAULT_READ_DATA = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic                       ready,
    input  logic [31:2]                addr,
    input  logic [31:0]                write_data,
    input  logic [3:0]                 byte_enable,
    input  logic                       write_req,
    input  logic                       read_req,
    output logic [31:0]                read_data,
    output logic                       read_data_valid,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    output logic [31:2]                s_addr,
    output logic [31:0]                s_write_data,
    output logic [3:0]                 s_byte_enable,
    output logic [NUM_SLAVES-1:0]      s_write_req,
    output logic [NUM_SLAVES-1:0]      s_read_req,
    input  logic [NUM_SLAVES*32-1:0]   s_read_data,
    input  logic [NUM_SLAVES-1:0]      s_read_data_valid,
    output logic                       idle,
    output logic                       decode_error,
    output logic                       protocol_error
);

    localparam int            TW       = tag_width(NUM_SLAVES);
    localparam logic [TW-1:0] UNMAPPED = TW'(NUM_SLAVES);

    logic [TW-1:0]                  sel, fifo_head;
    logic [NUM_SLAVES-1:0]          sel_oh;
    logic                           sel_ready, unmapped;
    logic                           fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;
    logic                           head_hit, head_unmapped, resp_err;
    bus_data_t                      head_data;
    logic                           decode_error_q, decode_error_d;
    logic                           protocol_error_q, protocol_error_d;

    // Descending scan so the lowest matching index wins
    always_comb begin
        sel       = UNMAPPED;
        sel_oh    = '0;
        sel_ready = 1'b1;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (REGION_IDS[4*i +: 4] == addr[REGION_MSB:REGION_LSB]) begin
                sel       = TW'(i);
                sel_ready = s_ready[i];
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign unmapped      = (sel == UNMAPPED);
    assign ready         = sel_ready && !fifo_full;
    assign s_addr        = addr;
    assign s_write_data  = write_data;
    assign s_byte_enable = byte_enable;
    assign s_write_req   = write_req ? sel_oh : '0;
    assign s_read_req    = read_req ? sel_oh : '0;

    bus_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (read_req && ready),
        .push_data (sel),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Only the slave named by the head tag may answer; any other strobe is dropped
    always_comb begin
        head_hit  = 1'b0;
        head_data = '0;
        resp_err  = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (!fifo_empty && fifo_head == TW'(k)) begin
                head_hit  = s_read_data_valid[k];
                head_data = s_read_data[32*k +: 32];
            end else if (s_read_data_valid[k]) begin
                resp_err = 1'b1;
            end
        end
        head_unmapped   = !fifo_empty && (fifo_head == UNMAPPED);
        read_data_valid = head_unmapped || head_hit;
        if (head_unmapped) begin
            read_data = DEFAULT_READ_DATA;
        end else if (head_hit) begin
            read_data = head_data;
        end else begin
            read_data = '0;
        end
    end

    assign fifo_pop = read_data_valid;
    assign idle     = (fifo_count == '0);

    always_comb begin
        decode_error_d   = decode_error_q || ((read_req || write_req) && ready && unmapped);
        protocol_error_d = protocol_error_q || resp_err;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            decode_error_q   <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            decode_error_q   <= decode_error_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign decode_error   = decode_error_q;
    assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_system_bus_router.sv
// tb/tb_system_bus_router.sv - scoreboard bench for system_bus_router
module tb_system_bus_router;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         ready;
    logic [31:2]  addr;
    logic [31:0]  write_data;
    logic [3:0]   byte_enable;
    logic         write_req, read_req;
    logic [31:0]  read_data;
    logic         read_data_valid;
    logic [3:0]   s_ready;
    logic [31:2]  s_addr;
    logic [31:0]  s_write_data;
    logic [3:0]   s_byte_enable;
    logic [3:0]   s_write_req, s_read_req;
    logic [127:0] s_read_data;
    logic [3:0]   s_read_data_valid;
    logic         idle, decode_error, protocol_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    system_bus_router dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ready             (ready),
        .addr              (addr),
        .write_data        (write_data),
        .byte_enable       (byte_enable),
        .write_req         (write_req),
        .read_req          (read_req),
        .read_data         (read_data),
        .read_data_valid   (read_data_valid),
        .s_ready           (s_ready),
        .s_addr            (s_addr),
        .s_write_data      (s_write_data),
        .s_byte_enable     (s_byte_enable),
        .s_write_req       (s_write_req),
        .s_read_req        (s_read_req),
        .s_read_data       (s_read_data),
        .s_read_data_valid (s_read_data_valid),
        .idle              (idle),
        .decode_error      (decode_error),
        .protocol_error    (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest expected value
    always @(negedge clk) begin
        if (read_data_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_response: got %h expected none", read_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (read_data !== e) begin
                    errors++;
                    $display("FAIL response_data: got %h expected %h", read_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_addr(input logic [31:0] a);
        addr = a[31:2];
    endtask

    task automatic slave_resp(input int k, input logic [31:0] d);
        s_read_data[32*k +: 32] = d;
        s_read_data_valid[k]    = 1'b1;
    endtask

    task automatic slave_clear();
        s_read_data_valid = '0;
        s_read_data       = '0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        read_req  = 1'b0;
        write_req = 1'b0;
        slave_clear();
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        addr = '0;
        write_data = 32'hCAFE_0001;
        byte_enable = 4'hF;
        write_req = 1'b0;
        read_req = 1'b0;
        s_ready = 4'hF;
        s_read_data = '0;
        s_read_data_valid = '0;
        set_addr(32'h1000_0040);
        step();
        do_reset();

        at_neg();
        check("reset_rdv", {31'd0, read_data_valid}, 32'd0);
        check("reset_idle", {31'd0, idle}, 32'd1);
        check("reset_decode_err", {31'd0, decode_error}, 32'd0);
        check("reset_protocol_err", {31'd0, protocol_error}, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd1);

        // single read to slave 0, response three cycles later
        step();
        read_req = 1'b1;
        at_neg();
        check("s0_read_req", {28'd0, s_read_req}, 32'h1);
        step();
        read_req = 1'b0;
        at_neg();
        check("s0_read_req_drop", {28'd0, s_read_req}, 32'h0);
        check("s0_not_idle", {31'd0, idle}, 32'd0);
        step();
        step();
        exp_q.push_back(32'hDEAD_BEEF);
        slave_resp(0, 32'hDEAD_BEEF);
        at_neg();
        check("s0_same_cycle_valid", {31'd0, read_data_valid}, 32'd1);
        step();
        slave_clear();
        at_neg();
        check("s0_idle_after", {31'd0, idle}, 32'd1);

        // in-order responses: slave 1 then slave 0
        step();
        set_addr(32'h2000_0000);
        read_req = 1'b1;
        step();
        set_addr(32'h1000_0000);
        step();
        read_req = 1'b0;
        exp_q.push_back(32'h22);
        slave_resp(1, 32'h22);
        step();
        slave_clear();
        exp_q.push_back(32'h11);
        slave_resp(0, 32'h11);
        step();
        slave_clear();
        at_neg();
        check("ordered_no_perr", {31'd0, protocol_error}, 32'd0);
        check("ordered_idle", {31'd0, idle}, 32'd1);

        // out-of-order: slave 0 answers before slave 1
        step();
        set_addr(32'h2000_0000);
        read_req = 1'b1;
        step();
        set_addr(32'h1000_0000);
        step();
        read_req = 1'b0;
        slave_resp(0, 32'h11);
        at_neg();
        check("ooo_dropped", {31'd0, read_data_valid}, 32'd0);
        step();
        slave_clear();
        at_neg();
        check("ooo_perr", {31'd0, protocol_error}, 32'd1);
        step();
        exp_q.push_back(32'h22);
        slave_resp(1, 32'h22);
        step();
        slave_clear();
        exp_q.push_back(32'h11);
        slave_resp(0, 32'h11);
        step();
        slave_clear();
        at_neg();
        check("ooo_drained", {31'd0, idle}, 32'd1);

        // fill the tag FIFO on slave 2
        step();
        set_addr(32'h3000_0000);
        read_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check($sformatf("fill_ready_%0d", i), {31'd0, ready}, 32'd1);
            step();
        end
        at_neg();
        check("full_ready_low", {31'd0, ready}, 32'd0);
        check("full_forward", {28'd0, s_read_req}, 32'h4);
        step();
        exp_q.push_back(32'hA0);
        slave_resp(2, 32'hA0);
        at_neg();
        check("no_bypass", {31'd0, ready}, 32'd0);
        step();
        slave_clear();
        at_neg();
        check("ready_after_pop", {31'd0, ready}, 32'd1);
        step();
        read_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(32'hA0 + i);
            slave_resp(2, 32'hA0 + i);
            step();
            slave_clear();
        end
        at_neg();
        check("fill_drained", {31'd0, idle}, 32'd1);

        // unmapped read
        step();
        set_addr(32'hF000_0000);
        read_req = 1'b1;
        at_neg();
        check("unmapped_no_rreq", {28'd0, s_read_req}, 32'h0);
        check("unmapped_ready", {31'd0, ready}, 32'd1);
        exp_q.push_back(32'h0);
        step();
        read_req = 1'b0;
        at_neg();
        check("unmapped_rdv", {31'd0, read_data_valid}, 32'd1);
        check("unmapped_decode_err", {31'd0, decode_error}, 32'd1);

        // unmapped write, from a clean reset
        step();
        do_reset();
        at_neg();
        check("pre_write_decode_err", {31'd0, decode_error}, 32'd0);
        step();
        set_addr(32'hF000_0000);
        write_req = 1'b1;
        at_neg();
        check("unmapped_no_wreq", {28'd0, s_write_req}, 32'h0);
        step();
        write_req = 1'b0;
        at_neg();
        check("unmapped_write_err", {31'd0, decode_error}, 32'd1);
        check("unmapped_write_idle", {31'd0, idle}, 32'd1);

        // reset with reads outstanding on slave 3
        step();
        set_addr(32'h4000_0000);
        read_req = 1'b1;
        step();
        step();
        step();
        read_req = 1'b0;
        at_neg();
        check("outstanding_busy", {31'd0, idle}, 32'd0);
        step();
        do_reset();
        at_neg();
        check("flush_idle", {31'd0, idle}, 32'd1);
        check("flush_decode_err", {31'd0, decode_error}, 32'd0);
        check("flush_protocol_err", {31'd0, protocol_error}, 32'd0);
        step();
        slave_resp(3, 32'h77);
        at_neg();
        check("late_resp_dropped", {31'd0, read_data_valid}, 32'd0);
        step();
        slave_clear();
        at_neg();
        check("late_resp_perr", {31'd0, protocol_error}, 32'd1);
        step();
        set_addr(32'h1000_0000);
        read_req = 1'b1;
        step();
        read_req = 1'b0;
        exp_q.push_back(32'h55);
        slave_resp(0, 32'h55);
        at_neg();
        check("post_reset_rdv", {31'd0, read_data_valid}, 32'd1);
        step();
        slave_clear();
        step();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
